// File: rtl/fullsub_pipe.sv
// rtl/fullsub_pipe.sv - pipelined chunked subtractor with valid/ready, saturate mode and overflow flag
module fullsub_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sub1,
    input  logic [WIDTH-1:0] sub2,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sub,
    output logic             cout_sub,
    output logic             ovf
);

    localparam int CW = WIDTH / STAGES;

    // Stage-input chain: element k is what stage k computes from on this cycle.
    // The minuend vector is rotated right one chunk per stage with the result
    // chunk inserted at the top, so after the last stage the whole result is
    // back in place. The subtrahend is shifted right one chunk per stage.
    // Each stage therefore always works on bits [CW-1:0], and at the last stage
    // those bits still hold the operand top chunks (and thus both MSBs).
    logic             v_c   [STAGES];
    logic             bor_c [STAGES];
    logic             m_c   [STAGES];
    logic [WIDTH-1:0] a_c   [STAGES];
    logic [WIDTH-1:0] b_c   [STAGES];

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign v_c[0]   = in_valid;
    assign bor_c[0] = 1'b0;
    assign m_c[0]   = mode;
    assign a_c[0]   = sub1;
    assign b_c[0]   = sub2;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW:0]          diff;
        logic [WIDTH+CW-1:0]  a_cat;
        logic [WIDTH-1:0]     a_next;

        assign diff   = {1'b0, a_c[k][CW-1:0]} - {1'b0, b_c[k][CW-1:0]} - {{CW{1'b0}}, bor_c[k]};
        assign a_cat  = {diff[CW-1:0], a_c[k]};
        assign a_next = a_cat[WIDTH+CW-1:CW];

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH+CW-1:0] b_cat;
            logic [WIDTH-1:0]    b_next;
            logic                v_q;
            logic                bor_q;
            logic                m_q;
            logic [WIDTH-1:0]    a_q;
            logic [WIDTH-1:0]    b_q;

            assign b_cat  = {{CW{1'b0}}, b_c[k]};
            assign b_next = b_cat[WIDTH+CW-1:CW];

            // Intermediate stage register: loads from the previous stage on advance, holds otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q   <= 1'b0;
                    bor_q <= 1'b0;
                    m_q   <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                end else if (advance) begin
                    v_q   <= v_c[k];
                    bor_q <= diff[CW];
                    m_q   <= m_c[k];
                    a_q   <= a_next;
                    b_q   <= b_next;
                end
            end

            assign v_c[k+1]   = v_q;
            assign bor_c[k+1] = bor_q;
            assign m_c[k+1]   = m_q;
            assign a_c[k+1]   = a_q;
            assign b_c[k+1]   = b_q;
        end else begin : g_last
            logic sat;
            logic ovf_next;

            // Operand MSBs are bit CW-1 of the incoming chunk; result MSB is the top bit of this chunk's difference.
            assign sat      = m_c[k] && diff[CW];
            assign ovf_next = (a_c[k][CW-1] != b_c[k][CW-1]) && (diff[CW-1] != a_c[k][CW-1]);

            // Output register: final borrow, optional clamp to zero, and signed overflow from the raw result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    sub       <= '0;
                    cout_sub  <= 1'b0;
                    ovf       <= 1'b0;
                end else if (advance) begin
                    out_valid <= v_c[k];
                    sub       <= sat ? '0 : a_next;
                    cout_sub  <= diff[CW];
                    ovf       <= ovf_next;
                end
            end
        end
    end

endmodule
